// File: rtl/ila_trigger_unit_pkg.sv
// ila_trigger_unit_pkg
// Shared encodings for the ILA trigger path: reduction type, per-channel
// trigger mode and trigger state machine encodings, plus a small helper
// returning the neutral element of the selected reduction.
// No ports (package).
package ila_trigger_unit_pkg;

   // reduce_type encodings
   localparam logic IOB_ILA_REDUCE_OR  = 1'b0;
   localparam logic IOB_ILA_REDUCE_AND = 1'b1;

   // trigger_type encodings (per channel)
   localparam logic IOB_ILA_SINGLE_TYPE     = 1'b0;
   localparam logic IOB_ILA_CONTINUOUS_TYPE = 1'b1;

   // Trigger state machine encodings
   localparam logic [1:0] IOB_ILA_TRIG_IDLE  = 2'b00;
   localparam logic [1:0] IOB_ILA_TRIG_ARMED = 2'b01;
   localparam logic [1:0] IOB_ILA_TRIG_FIRED = 2'b10;

   // A masked-off channel must not influence the reduction, so it presents
   // the identity element: 0 for OR, 1 for AND.
   function automatic logic reduce_identity(input logic reduce_type);
      return (reduce_type == IOB_ILA_REDUCE_AND);
   endfunction

endpackage

// File: rtl/ila_trigger_channel.sv
// ila_trigger_channel
// One trigger channel: polarity invert, optional rising-edge detect,
// continuous-mode sticky latch and mask-to-identity for the reduction.
// Optional feature macro: IOB_ILA_EDGE_EN (adds edge_mode input and the
// per-channel previous-value register).
// Ports:
//   clk, rst       clock / asynchronous active-high reset
//   trigger_in     raw trigger bit
//   mask           1 = channel participates in the reduction
//   negate         1 = invert trigger polarity
//   trigger_type   SINGLE / CONTINUOUS mode
//   edge_mode      (IOB_ILA_EDGE_EN only) 1 = rising-edge sensitive
//   reduce_type    OR / AND, selects identity value for a masked channel
//   lat_clr        clears the continuous latch (arm or clear pulse)
//   lat_en         latch may accumulate (trigger unit is ARMED)
//   v_masked       channel value presented to the reduction
module ila_trigger_channel
   import ila_trigger_unit_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic trigger_in,
   input  logic mask,
   input  logic negate,
   input  logic trigger_type,
`ifdef IOB_ILA_EDGE_EN
   input  logic edge_mode,
`endif
   input  logic reduce_type,
   input  logic lat_clr,
   input  logic lat_en,
   output logic v_masked
);

   logic c;
   logic e;
   logic v;
   logic lat_q, lat_d;

   assign c = trigger_in ^ negate;

`ifdef IOB_ILA_EDGE_EN
   logic c_prev_q, c_prev_d;

   // Tracks c every cycle, including the arm cycle, so a level already
   // present when arming is not seen as an edge.
   assign c_prev_d = c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) c_prev_q <= 1'b0;
      else     c_prev_q <= c_prev_d;
   end

   assign e = edge_mode ? (c & ~c_prev_q) : c;
`else
   assign e = c;
`endif

   always_comb begin
      lat_d = lat_q;
      if (lat_clr)     lat_d = 1'b0;
      else if (lat_en) lat_d = lat_q | e;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) lat_q <= 1'b0;
      else     lat_q <= lat_d;
   end

   always_comb begin
      v = e;
      unique case (trigger_type)
         IOB_ILA_SINGLE_TYPE:     v = e;
         IOB_ILA_CONTINUOUS_TYPE: v = lat_q | e;
      endcase
   end

   assign v_masked = mask ? v : reduce_identity(reduce_type);

endmodule

// File: rtl/ila_trigger_unit.sv
// ila_trigger_unit
// Multi-channel ILA trigger: N_TRIG channels reduced by OR/AND, an
// IDLE/ARMED/FIRED state machine and a saturating hit counter that fires
// on the count_target-th qualifying cycle. fired gates post-trigger capture.
// Optional feature macro: IOB_ILA_EDGE_EN (per-channel rising-edge mode).
// Ports:
//   clk, rst       clock / asynchronous active-high reset
//   trigger_in     raw trigger signals [N_TRIG]
//   mask           per-channel enable [N_TRIG]
//   negate         per-channel polarity invert [N_TRIG]
//   trigger_type   per-channel SINGLE / CONTINUOUS [N_TRIG]
//   edge_mode      (IOB_ILA_EDGE_EN only) per-channel edge mode [N_TRIG]
//   reduce_type    OR / AND reduction
//   count_target   occurrence to fire on, 0 behaves as 1 [CNT_W]
//   arm            arm / restart pulse
//   clear          disarm pulse, wins over arm
//   hit            reduced condition while ARMED (combinational)
//   hit_count      qualifying cycles since arm, saturating [CNT_W]
//   armed          state is ARMED
//   fired          state is FIRED
module ila_trigger_unit
   import ila_trigger_unit_pkg::*;
#(
   parameter int N_TRIG = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_TRIG-1:0] trigger_in,
   input  logic [N_TRIG-1:0] mask,
   input  logic [N_TRIG-1:0] negate,
   input  logic [N_TRIG-1:0] trigger_type,
`ifdef IOB_ILA_EDGE_EN
   input  logic [N_TRIG-1:0] edge_mode,
`endif
   input  logic              reduce_type,
   input  logic [CNT_W-1:0]  count_target,
   input  logic              arm,
   input  logic              clear,
   output logic              hit,
   output logic [CNT_W-1:0]  hit_count,
   output logic              armed,
   output logic              fired
);

   logic [N_TRIG-1:0] v_masked;
   logic              cond;
   logic              is_armed;
   logic              lat_clr;
   logic [1:0]        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W:0]    cnt_inc;
   logic [CNT_W-1:0]  target_eff;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (&x) ? x : x + CNT_W'(1);
   endfunction

   assign is_armed = (state_q == IOB_ILA_TRIG_ARMED);
   // Entry to IDLE only happens through clear, so arm|clear covers every
   // latch-clearing event besides reset.
   assign lat_clr  = arm | clear;

   for (genvar i = 0; i < N_TRIG; i++) begin : g_ch
      ila_trigger_channel u_ch (
         .clk          (clk),
         .rst          (rst),
         .trigger_in   (trigger_in[i]),
         .mask         (mask[i]),
         .negate       (negate[i]),
         .trigger_type (trigger_type[i]),
`ifdef IOB_ILA_EDGE_EN
         .edge_mode    (edge_mode[i]),
`endif
         .reduce_type  (reduce_type),
         .lat_clr      (lat_clr),
         .lat_en       (is_armed),
         .v_masked     (v_masked[i])
      );
   end

   // Masked channels already carry the identity, so a plain reduction
   // yields 0 (OR) / 1 (AND) when every channel is masked.
   always_comb begin
      cond = |v_masked;
      unique case (reduce_type)
         IOB_ILA_REDUCE_OR:  cond = |v_masked;
         IOB_ILA_REDUCE_AND: cond = &v_masked;
      endcase
   end

   assign hit = cond & is_armed;

   // Unsaturated compare so a counter sitting at its maximum still fires.
   assign cnt_inc    = {1'b0, cnt_q} + (CNT_W+1)'(1);
   assign target_eff = (count_target == '0) ? CNT_W'(1) : count_target;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (clear) begin
         state_d = IOB_ILA_TRIG_IDLE;
      end else if (arm) begin
         state_d = IOB_ILA_TRIG_ARMED;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IOB_ILA_TRIG_IDLE: begin
            end
            IOB_ILA_TRIG_ARMED: begin
               if (cond) begin
                  cnt_d = sat_inc(cnt_q);
                  if (cnt_inc >= {1'b0, target_eff}) state_d = IOB_ILA_TRIG_FIRED;
               end
            end
            IOB_ILA_TRIG_FIRED: begin
            end
            default: state_d = IOB_ILA_TRIG_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IOB_ILA_TRIG_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign hit_count = cnt_q;
   assign armed     = is_armed;
   assign fired     = (state_q == IOB_ILA_TRIG_FIRED);

endmodule

// File: tb/tb_ila_trigger_unit.sv
module tb_ila_trigger_unit;
   import ila_trigger_unit_pkg::*;

   localparam int N    = 4;
   localparam int CW   = 4;
   localparam int MAXC = (1 << CW) - 1;
   localparam int S_IDLE = 0, S_ARMED = 1, S_FIRED = 2;
`ifdef IOB_ILA_EDGE_EN
   localparam bit EDGE_EN = 1'b1;
`else
   localparam bit EDGE_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  trigger_in, mask, negate, trigger_type, edge_mode;
   logic          reduce_type;
   logic [CW-1:0] count_target;
   logic          arm, clear;
   logic          hit, armed, fired;
   logic [CW-1:0] hit_count;

   ila_trigger_unit #(.N_TRIG(N), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .trigger_in   (trigger_in),
      .mask         (mask),
      .negate       (negate),
      .trigger_type (trigger_type),
`ifdef IOB_ILA_EDGE_EN
      .edge_mode    (edge_mode),
`endif
      .reduce_type  (reduce_type),
      .count_target (count_target),
      .arm          (arm),
      .clear        (clear),
      .hit          (hit),
      .hit_count    (hit_count),
      .armed        (armed),
      .fired        (fired)
   );

   always #5 clk = ~clk;

   typedef struct {
      int hit;
      int cnt;
      int armed;
      int fired;
   } exp_t;

   exp_t q[$];
   int checks   = 0;
   int failures = 0;

   // Reference model state
   int      m_st  = S_IDLE;
   int      m_cnt = 0;
   bit [N-1:0] m_lat  = '0;
   bit [N-1:0] m_prev = '0;

   // Staged configuration, applied together with the cycle's inputs
   logic          s_rt;
   logic [N-1:0]  s_mk, s_ng, s_tt, s_em;
   logic [CW-1:0] s_tg;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic model_reset();
      m_st = S_IDLE; m_cnt = 0; m_lat = '0; m_prev = '0;
   endtask

   // Evaluate one cycle of the reference model on the currently driven
   // inputs: push the expected outputs for this cycle, then advance.
   task automatic eval();
      bit [N-1:0] c, e, v;
      bit cond;
      int tgt;
      exp_t x;
      #1;
      for (int i = 0; i < N; i++) begin
         c[i] = trigger_in[i] ^ negate[i];
         e[i] = (EDGE_EN && edge_mode[i]) ? (c[i] && !m_prev[i]) : c[i];
         v[i] = (trigger_type[i] == IOB_ILA_CONTINUOUS_TYPE) ? (m_lat[i] || e[i]) : e[i];
      end
      if (reduce_type == IOB_ILA_REDUCE_OR) begin
         cond = 1'b0;
         for (int i = 0; i < N; i++) if (mask[i] && v[i]) cond = 1'b1;
      end else begin
         cond = 1'b1;
         for (int i = 0; i < N; i++) if (mask[i] && !v[i]) cond = 1'b0;
      end
      x.hit   = (cond && m_st == S_ARMED) ? 1 : 0;
      x.cnt   = m_cnt;
      x.armed = (m_st == S_ARMED) ? 1 : 0;
      x.fired = (m_st == S_FIRED) ? 1 : 0;
      q.push_back(x);

      tgt = (count_target == 0) ? 1 : int'(count_target);
      if (clear) begin
         m_st = S_IDLE; m_lat = '0;
      end else if (arm) begin
         m_st = S_ARMED; m_cnt = 0; m_lat = '0;
      end else if (m_st == S_ARMED) begin
         m_lat = m_lat | e;
         if (cond) begin
            if (m_cnt + 1 >= tgt) m_st = S_FIRED;
            m_cnt = (m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1;
         end
      end
      m_prev = c;
   endtask

   task automatic cfg(input logic rt, input logic [N-1:0] mk, ng, tt, em, input logic [CW-1:0] tg);
      s_rt = rt; s_mk = mk; s_ng = ng; s_tt = tt; s_em = em; s_tg = tg;
   endtask

   task automatic cyc(input logic [N-1:0] ti, input logic a, input logic c);
      @(negedge clk);
      trigger_in = ti; arm = a; clear = c;
      reduce_type = s_rt; mask = s_mk; negate = s_ng;
      trigger_type = s_tt; edge_mode = s_em; count_target = s_tg;
      eval();
   endtask

   // Monitor: compares DUT outputs against the oldest expected entry
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         #2;
         if (q.size() > 0) begin
            x = q.pop_front();
            chk("mon_hit",       32'(hit),       32'(x.hit));
            chk("mon_hit_count", 32'(hit_count), 32'(x.cnt));
            chk("mon_armed",     32'(armed),     32'(x.armed));
            chk("mon_fired",     32'(fired),     32'(x.fired));
         end
      end
   end

   initial begin
      rst = 1'b1;
      trigger_in = '0; mask = '0; negate = '0; trigger_type = '0; edge_mode = '0;
      reduce_type = IOB_ILA_REDUCE_OR; count_target = '0; arm = 1'b0; clear = 1'b0;
      cfg(IOB_ILA_REDUCE_OR, '0, '0, '0, '0, '0);
      #2;
      chk("rst_hit",       32'(hit),       0);
      chk("rst_armed",     32'(armed),     0);
      chk("rst_fired",     32'(fired),     0);
      chk("rst_hit_count", 32'(hit_count), 0);
      #10 rst = 1'b0;

      // OR, single channel 0, fire on first occurrence
      cfg(IOB_ILA_REDUCE_OR, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'd1);
      cyc(4'b0000, 1'b1, 1'b0);
      cyc(4'b0001, 1'b0, 1'b0);
      chk("or_hit", 32'(hit), 1);
      cyc(4'b0000, 1'b0, 1'b0);
      chk("or_fired", 32'(fired), 1);
      chk("or_count", 32'(hit_count), 1);
      chk("or_hit_after_fire", 32'(hit), 0);

      // AND with negate on channel 1; arm from FIRED restarts
      cfg(IOB_ILA_REDUCE_AND, 4'b0011, 4'b0010, 4'b0000, 4'b0000, 4'd1);
      cyc(4'b0000, 1'b1, 1'b0);
      cyc(4'b0001, 1'b0, 1'b0);
      chk("rearm_armed", 32'(armed), 1);
      chk("rearm_count", 32'(hit_count), 0);
      chk("and_hit", 32'(hit), 1);
      cyc(4'b0000, 1'b0, 1'b0);
      chk("and_fired", 32'(fired), 1);
      cyc(4'b0000, 1'b1, 1'b0);
      cyc(4'b0011, 1'b0, 1'b0);
      chk("and_nohit", 32'(hit), 0);
      cyc(4'b0000, 1'b0, 1'b0);
      chk("and_still_armed", 32'(armed), 1);
      cfg(IOB_ILA_REDUCE_AND, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'd1);
      cyc(4'b0000, 1'b1, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0);
      chk("and_allmasked_hit", 32'(hit), 1);
      cyc(4'b0000, 1'b0, 1'b0);
      chk("and_allmasked_fired", 32'(fired), 1);

      // Third occurrence fires; further pulses leave the count frozen
      cfg(IOB_ILA_REDUCE_OR, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'd3);
      cyc(4'b0000, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cyc(4'b0001, 1'b0, 1'b0);
         cyc(4'b0000, 1'b0, 1'b0);
         if (k == 1) chk("tgt3_not_yet", 32'(fired), 0);
      end
      chk("tgt3_fired", 32'(fired), 1);
      chk("tgt3_count", 32'(hit_count), 3);
      cyc(4'b0001, 1'b0, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0);
      chk("tgt3_frozen", 32'(hit_count), 3);

      // Continuous channel 1 stays hit after one pulse; clear drops it
      cfg(IOB_ILA_REDUCE_OR, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'd15);
      cyc(4'b0000, 1'b1, 1'b0);
      cyc(4'b0010, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cyc(4'b0000, 1'b0, 1'b0);
         chk("cont_hit_held", 32'(hit), 1);
      end
      cyc(4'b0000, 1'b0, 1'b1);
      cyc(4'b0000, 1'b0, 1'b0);
      chk("clear_armed", 32'(armed), 0);
      chk("clear_hit", 32'(hit), 0);
      chk("clear_count_kept", 32'(hit_count), 4);
      cyc(4'b0000, 1'b1, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0);
      chk("latch_cleared", 32'(hit), 0);

      // arm and clear together: clear wins
      cyc(4'b0000, 1'b0, 1'b1);
      cyc(4'b0000, 1'b1, 1'b1);
      cyc(4'b0000, 1'b0, 1'b0);
      chk("arm_clear_idle", 32'(armed), 0);

      // Asynchronous reset while ARMED
      cyc(4'b0000, 1'b1, 1'b0);
      cyc(4'b0010, 1'b0, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_hit",   32'(hit),   0);
      chk("arst_armed", 32'(armed), 0);
      chk("arst_fired", 32'(fired), 0);
      chk("arst_count", 32'(hit_count), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;

`ifdef IOB_ILA_EDGE_EN
      // Level held across arm is ignored; the next rising edge hits once
      cfg(IOB_ILA_REDUCE_OR, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 4'd1);
      cyc(4'b0001, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         cyc(4'b0001, 1'b0, 1'b0);
         chk("edge_level_nohit", 32'(hit), 0);
      end
      cyc(4'b0000, 1'b0, 1'b0);
      chk("edge_low_nohit", 32'(hit), 0);
      cyc(4'b0001, 1'b0, 1'b0);
      chk("edge_rise_hit", 32'(hit), 1);
      cyc(4'b0001, 1'b0, 1'b0);
      chk("edge_fired", 32'(fired), 1);
      chk("edge_count", 32'(hit_count), 1);
`endif

      // Randomized traffic against the reference model
      for (int n = 0; n < 3000; n++) begin
         logic [N-1:0] ti;
         if ($urandom_range(0, 15) == 0)
            cfg(1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                4'($urandom), 4'($urandom_range(0, 5)));
         if ($urandom_range(0, 31) == 0) s_tg = 4'($urandom_range(0, 5));
         for (int i = 0; i < N; i++) ti[i] = ($urandom_range(0, 3) == 0);
         cyc(ti, ($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0));
      end

      repeat (2) @(negedge clk);
      #3;
      chk("queue_drained", 32'(q.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
